// File: rtl/modular_inverse.sv
// Modular multiplicative inverse a^-1 mod m by iterative extended Euclid.
// Division is restoring shift-subtract and q*t1 mod m is double-and-add, so no divider or multiplier is used.
module modular_inverse #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             ready_in,
    input  logic [WIDTH-1:0] value_in,
    input  logic [WIDTH-1:0] modulus_in,
    output logic [WIDTH-1:0] value_out,
    output logic             exists_out,
    output logic             busy_out,
    output logic             valid_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned EXT_W = WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_MUL,
        S_UPDATE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  r0_q, r0_d;
    logic [WIDTH-1:0]  r1_q, r1_d;
    logic [WIDTH-1:0]  t0_q, t0_d;
    logic [WIDTH-1:0]  t1_q, t1_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic              exists_q, exists_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic [EXT_W-1:0]  m_ext;
    logic [EXT_W-1:0]  r1_ext;
    logic [EXT_W-1:0]  div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_rem_next;
    logic [WIDTH-1:0]  div_q_next;
    logic [EXT_W-1:0]  mul_dbl;
    logic [WIDTH-1:0]  mul_dbl_red;
    logic [EXT_W-1:0]  mul_add;
    logic [WIDTH-1:0]  mul_add_red;
    logic [WIDTH-1:0]  mul_acc_next;
    logic [WIDTH-1:0]  t_new;
    logic [WIDTH-1:0]  t0_mod;
    logic              done_exists;
    logic              cnt_last;

    assign m_ext  = {1'b0, m_q};
    assign r1_ext = {1'b0, r1_q};

    // One restoring-division step: shift in the next dividend bit (held in q_q), subtract if it fits.
    assign div_shift    = {rem_q, q_q[WIDTH-1]};
    assign div_ge       = (div_shift >= r1_ext);
    assign div_rem_next = WIDTH'(div_ge ? (div_shift - r1_ext) : div_shift);
    assign div_q_next   = {q_q[WIDTH-2:0], div_ge};

    // One double-and-add step modulo m; acc and t1 are both below m so a single subtract suffices.
    assign mul_dbl      = {acc_q, 1'b0};
    assign mul_dbl_red  = WIDTH'((mul_dbl >= m_ext) ? (mul_dbl - m_ext) : mul_dbl);
    assign mul_add      = {1'b0, mul_dbl_red} + {1'b0, t1_q};
    assign mul_add_red  = WIDTH'((mul_add >= m_ext) ? (mul_add - m_ext) : mul_add);
    assign mul_acc_next = q_q[WIDTH-1] ? mul_add_red : mul_dbl_red;

    // t0 - p kept in [0, m); the modulo-2^WIDTH wrap makes the "+m" case exact.
    assign t_new = (t0_q >= acc_q) ? (t0_q - acc_q) : (t0_q - acc_q + m_q);

    // t0 only reaches m when m == 1 (initial t1 = 1), so one conditional subtract reduces it.
    assign t0_mod      = (t0_q >= m_q) ? (t0_q - m_q) : t0_q;
    assign done_exists = (r0_q == WIDTH'(1)) && (m_q != '0);
    assign cnt_last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= S_IDLE;
            m_q      <= '0;
            r0_q     <= '0;
            r1_q     <= '0;
            t0_q     <= '0;
            t1_q     <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            exists_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            r0_q     <= r0_d;
            r1_q     <= r1_d;
            t0_q     <= t0_d;
            t1_q     <= t1_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            exists_q <= exists_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        r0_d     = r0_q;
        r1_d     = r1_q;
        t0_d     = t0_q;
        t1_d     = t1_q;
        q_d      = q_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        exists_d = exists_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ready_in) begin
                    m_d     = modulus_in;
                    r0_d    = modulus_in;
                    r1_d    = value_in;
                    t0_d    = '0;
                    t1_d    = WIDTH'(1);
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((m_q == '0) || (r1_q == '0)) begin
                    state_d = S_DONE;
                end else begin
                    q_d     = r0_q;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                q_d   = div_q_next;
                rem_d = div_rem_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                acc_d = mul_acc_next;
                q_d   = {q_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                r0_d    = r1_q;
                r1_d    = rem_q;
                t0_d    = t1_q;
                t1_d    = t_new;
                state_d = S_CHECK;
            end
            S_DONE: begin
                exists_d = done_exists;
                value_d  = done_exists ? t0_mod : '0;
                busy_d   = 1'b0;
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign value_out  = value_q;
    assign exists_out = exists_q;
    assign busy_out   = busy_q;
    assign valid_out  = valid_q;

endmodule

// File: tb/tb_modular_inverse.sv
// Scoreboard bench for modular_inverse: expected results queued at start, checked on valid_out.
module tb_modular_inverse;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned TIMEOUT_CYC = 4000;

    logic             clk_in;
    logic             rst_in;
    logic             ready_in;
    logic [WIDTH-1:0] value_in;
    logic [WIDTH-1:0] modulus_in;
    logic [WIDTH-1:0] value_out;
    logic             exists_out;
    logic             busy_out;
    logic             valid_out;

    typedef struct {
        logic [WIDTH-1:0] v;
        logic             e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_results = 0;

    modular_inverse #(.WIDTH(WIDTH)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .ready_in   (ready_in),
        .value_in   (value_in),
        .modulus_in (modulus_in),
        .value_out  (value_out),
        .exists_out (exists_out),
        .busy_out   (busy_out),
        .valid_out  (valid_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Independent reference: signed extended Euclid on 64-bit integers.
    function automatic exp_t model(input longint a, input longint m);
        exp_t   r;
        longint old_r, cur_r, old_s, cur_s, q, tmp;
        r.v = '0;
        r.e = 1'b0;
        if (m == 0) return r;
        old_r = a; cur_r = m; old_s = 1; cur_s = 0;
        while (cur_r != 0) begin
            q     = old_r / cur_r;
            tmp   = old_r - q * cur_r;
            old_r = cur_r;
            cur_r = tmp;
            tmp   = old_s - q * cur_s;
            old_s = cur_s;
            cur_s = tmp;
        end
        if (old_r == 1) begin
            r.e = 1'b1;
            r.v = WIDTH'(((old_s % m) + m) % m);
        end
        return r;
    endfunction

    always @(negedge clk_in) begin
        if (valid_out) begin
            n_results++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("value", 32'(value_out), 32'(mon_e.v));
                check_eq("exists", 32'(exists_out), 32'(mon_e.e));
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m,
                          input logic [WIDTH-1:0] ev, input logic ee, input bit hold);
        exp_t e;
        bit   got;
        bit   busy_ok;
        int   start;
        @(negedge clk_in); #1;
        value_in   = a;
        modulus_in = m;
        ready_in   = 1'b1;
        e.v = ev;
        e.e = ee;
        sb.push_back(e);
        start = n_results;
        @(negedge clk_in); #1;
        if (!hold) ready_in = 1'b0;
        value_in   = WIDTH'($urandom);
        modulus_in = WIDTH'($urandom);
        check_eq("busy_set", 32'(busy_out), 32'd1);
        got     = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            if (valid_out) begin
                got = 1'b1;
                ready_in = 1'b0;
                break;
            end
            if (!busy_out) busy_ok = 1'b0;
            if (hold) value_in = WIDTH'($urandom);
            @(negedge clk_in); #1;
        end
        check_eq("timeout", 32'(got), 32'd1);
        check_eq("busy_hold", 32'(busy_ok), 32'd1);
        check_eq("busy_low_at_valid", 32'(busy_out), 32'd0);
        check_eq("result_count", 32'(n_results - start), 32'd1);
        @(negedge clk_in); #1;
        check_eq("valid_pulse", 32'(valid_out), 32'd0);
        if (hold) begin
            repeat (60) @(negedge clk_in);
            #1;
            check_eq("one_result", 32'(n_results - start), 32'd1);
            check_eq("idle_after_hold", 32'(busy_out), 32'd0);
        end
    endtask

    initial begin
        exp_t r;
        int   start;
        logic [WIDTH-1:0] ra, rm;
        rst_in     = 1'b0;
        ready_in   = 1'b0;
        value_in   = '0;
        modulus_in = '0;
        repeat (3) @(negedge clk_in);
        check_eq("rst_value", 32'(value_out), 32'd0);
        check_eq("rst_exists", 32'(exists_out), 32'd0);
        check_eq("rst_busy", 32'(busy_out), 32'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        #1 rst_in = 1'b1;

        run_op(16'd3, 16'd7, 16'd5, 1'b1, 1'b0);
        run_op(16'd17, 16'd3120, 16'd2753, 1'b1, 1'b0);
        run_op(16'd10, 16'd7, 16'd5, 1'b1, 1'b0);
        run_op(16'd6, 16'd9, 16'd0, 1'b0, 1'b0);
        run_op(16'd0, 16'd5, 16'd0, 1'b0, 1'b0);
        run_op(16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        run_op(16'd0, 16'd1, 16'd0, 1'b1, 1'b0);
        run_op(16'd7, 16'd7, 16'd0, 1'b0, 1'b0);
        run_op(16'd9, 16'd1, 16'd0, 1'b1, 1'b0);

        r = model(64'd65535, 64'd65521);
        run_op(16'd65535, 16'd65521, r.v, r.e, 1'b0);
        check_eq("inv_prod", 32'((64'd65535 * 64'(value_out)) % 64'd65521), 32'd1);

        run_op(16'd5, 16'd11, 16'd9, 1'b1, 1'b1);

        for (int k = 0; k < 8; k++) begin
            ra = WIDTH'($urandom);
            rm = WIDTH'($urandom_range(2, 65535));
            r  = model(64'(ra), 64'(rm));
            run_op(ra, rm, r.v, r.e, 1'b0);
        end

        run_op(16'd3, 16'd7, 16'd5, 1'b1, 1'b0);
        @(negedge clk_in); #1;
        value_in   = 16'd3;
        modulus_in = 16'd7;
        ready_in   = 1'b1;
        @(negedge clk_in); #1;
        ready_in = 1'b0;
        repeat (6) @(negedge clk_in);
        #1;
        start  = n_results;
        rst_in = 1'b0;
        #1;
        check_eq("abort_value", 32'(value_out), 32'd0);
        check_eq("abort_exists", 32'(exists_out), 32'd0);
        check_eq("abort_busy", 32'(busy_out), 32'd0);
        repeat (3) @(negedge clk_in);
        #1 rst_in = 1'b1;
        repeat (60) @(negedge clk_in);
        #1;
        check_eq("abort_no_valid", 32'(n_results - start), 32'd0);
        run_op(16'd3, 16'd7, 16'd5, 1'b1, 1'b0);

        repeat (5) @(negedge clk_in);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
